f_fetch_unit: RTL and testbench
===============================

F_FETCH_UNIT -- requirements
Module: f_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port NPC, input, 32, next fetch address from the D-stage next-PC logic.
REQ-004 SHALL have port stall, input, 1, hazard-unit freeze of F/D.
REQ-005 SHALL have port F_PC, output, 32, current fetch address, also fed back to next-PC logic.
REQ-006 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_ack (input, 1), imem_rdata (input, 32): instruction-memory request/ack handshake.
REQ-007 SHALL have ports D_instr (output, 32), D_PC (output, 32), D_valid (output, 1): F/D pipeline register contents.
REQ-008 SHALL have port D_excCode, output, 5, fetch exception code for D stage.

Function
REQ-009 SHALL implement states S_REQ (request outstanding) and S_HOLD (word fetched, D frozen).
REQ-010 In S_REQ SHALL drive imem_req=1 and imem_addr=F_PC; in S_HOLD SHALL drive imem_req=0.
REQ-011 S_REQ, imem_ack=1, stall=0: D_instr<=imem_rdata, D_PC<=F_PC, D_valid<=1, F_PC<=NPC, stay S_REQ (one instruction per cycle at zero-wait memory).
REQ-012 S_REQ, imem_ack=1, stall=1: imem_rdata and F_PC captured in hold buffer, D registers and F_PC unchanged, go S_HOLD.
REQ-013 S_REQ, imem_ack=0, stall=0: D_valid<=0 (bubble), F_PC unchanged, stay S_REQ.
REQ-014 S_REQ, imem_ack=0, stall=1: all registers unchanged.
REQ-015 S_HOLD, stall=1: all registers unchanged; S_HOLD, stall=0: D loaded from hold buffer, D_valid<=1, F_PC<=NPC, go S_REQ.
REQ-016 imem_ack SHALL be ignored while imem_req=0.
REQ-017 F_PC SHALL only change on a D load; NPC sampled exactly on that edge; no 32-bit overflow check (wraps).
REQ-018 stall SHALL dominate: D registers never change while stall=1.

Reset
REQ-019 On reset: F_PC=0x0000_3000, state S_REQ, D_instr=0, D_PC=0x0000_3000, D_valid=0, D_excCode=0, hold buffer cleared.
REQ-020 Reset mid-handshake (S_REQ or S_HOLD) SHALL discard the pending/held word; memory response in the reset cycle ignored.
REQ-021 imem_req SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-022 Macro F_FETCH_EXC_EN SHALL enable fetch-address checking.
REQ-023 With F_FETCH_EXC_EN: F_PC[1:0]!=0 or F_PC outside 0x0000_3000..0x0000_6FFF -> imem_req=0, treated as immediate ack with rdata=0 (nop), D_excCode<=4 (AdEL) on that D load; legal fetch loads D_excCode=0.
REQ-024 Without F_FETCH_EXC_EN: every address requested, D_excCode constant 0.

Structure
REQ-025 Shared package cpu_pkg SHALL hold PC_RESET (0x0000_3000), IM_LO/IM_HI bounds, EXC_ADEL (5'd4), fetch state encoding.
REQ-026 Hold buffer (instr, PC, excCode; load/clear) SHALL be sub-module f_hold_buf; FSM and F_PC in f_fetch_unit.

Verification
REQ-027 Reset, imem_ack tied 1, stall=0, NPC=F_PC+4 -> D_PC 0x3000, 0x3004, 0x3008 on consecutive cycles, D_valid=1 from cycle 2.
REQ-028 Ack arriving 3 cycles after request for 0x3004 -> D_valid=0 for 2 cycles, then D_PC=0x3004 with correct instr; F_PC held at 0x3004 throughout.
REQ-029 stall=1 on ack cycle for 0x3008, held 2 cycles -> state S_HOLD, imem_req=0, D unchanged; on release D_PC=0x3008 with captured word, F_PC<=NPC.
REQ-030 D_PC=0x3000 branch, NPC=0x3100 at load of 0x3004 -> next fetch addresses 0x3004 then 0x3100 (delay slot preserved).
REQ-031 Reset asserted in S_HOLD -> next cycle F_PC=0x3000, D_valid=0, held word never appears on D_instr.
REQ-032 With F_FETCH_EXC_EN, NPC=0x3002 -> no imem_req, D_PC=0x3002, D_instr=0, D_excCode=4; NPC=0x7000 same; without macro D_excCode stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset PC, instruction-memory window, exception codes
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/f_hold_buf.sv
// Hold buffer for a fetched word (instr, PC, excCode) captured while the
// F/D register is frozen; cleared on reset so a stale word never escapes.
module f_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  exc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [4:0]  exc_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [4:0]  exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      exc_q   <= 5'd0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      exc_q   <= exc_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign exc_o   = exc_q;

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: F_PC, imem request/ack handshake and the F/D register.
// Define F_FETCH_EXC_EN to trap misaligned/out-of-window fetches as AdEL.
import cpu_pkg::*;

module f_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        stall,
  output logic [31:0] F_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic [4:0]  D_excCode
);

  fetch_state_e state_q;
  logic [31:0]  fPc_q;
  logic [31:0]  dInstr_q;
  logic [31:0]  dPc_q;
  logic         dValid_q;
  logic [4:0]   dExc_q;

  logic         addrBad;
  logic         fetchAck;
  logic [31:0]  fetchInstr;
  logic [4:0]   fetchExc;
  logic         holdLoad;
  logic [31:0]  holdInstr;
  logic [31:0]  holdPc;
  logic [4:0]   holdExc;

`ifdef F_FETCH_EXC_EN
  assign addrBad = (fPc_q[1:0] != 2'b00) || (fPc_q < IM_LO) || (fPc_q > IM_HI);
`else
  assign addrBad = 1'b0;
`endif

  // An illegal address never reaches memory; it completes at once as a nop.
  assign imem_req   = (state_q == S_REQ) && !addrBad;
  assign imem_addr  = fPc_q;
  assign fetchAck   = (state_q == S_REQ) && (addrBad || imem_ack);
  assign fetchInstr = addrBad ? 32'h0 : imem_rdata;
  assign fetchExc   = addrBad ? EXC_ADEL : EXC_NONE;
  assign holdLoad   = fetchAck && stall;

  f_hold_buf u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (holdLoad),
    .instr_i (fetchInstr),
    .pc_i    (fPc_q),
    .exc_i   (fetchExc),
    .instr_o (holdInstr),
    .pc_o    (holdPc),
    .exc_o   (holdExc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      fPc_q    <= PC_RESET;
      dInstr_q <= 32'h0;
      dPc_q    <= PC_RESET;
      dValid_q <= 1'b0;
      dExc_q   <= EXC_NONE;
    end else begin
      case (state_q)
        S_REQ: begin
          if (fetchAck && !stall) begin
            dInstr_q <= fetchInstr;
            dPc_q    <= fPc_q;
            dValid_q <= 1'b1;
            dExc_q   <= fetchExc;
            fPc_q    <= NPC;
          end else if (fetchAck) begin
            state_q <= S_HOLD;
          end else if (!stall) begin
            dValid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            dInstr_q <= holdInstr;
            dPc_q    <= holdPc;
            dValid_q <= 1'b1;
            dExc_q   <= holdExc;
            fPc_q    <= NPC;
            state_q  <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign F_PC      = fPc_q;
  assign D_instr   = dInstr_q;
  assign D_PC      = dPc_q;
  assign D_valid   = dValid_q;
  assign D_excCode = dExc_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed scenarios then random
// traffic, all checked against a transaction-level fetch model.
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        stall;
  logic [31:0] F_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] D_instr;
  logic [31:0] D_PC;
  logic        D_valid;
  logic [4:0]  D_excCode;

  int compared = 0;
  int mismatched = 0;

  f_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .NPC        (NPC),
    .stall      (stall),
    .F_PC       (F_PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .D_instr    (D_instr),
    .D_PC       (D_PC),
    .D_valid    (D_valid),
    .D_excCode  (D_excCode)
  );

  always #5 clk = ~clk;

  // Model: a fetched word is {instr, pc, exc}; at most one may be parked.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
  } word_t;

  logic [31:0] mPc;
  word_t       mD;
  logic        mValid;
  word_t       mParked[$];
  bit          modelKnown = 0;

  function automatic bit illegalAddr(input logic [31:0] pc);
`ifdef F_FETCH_EXC_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ack, input logic [31:0] rdata,
                               input logic stl, input logic [31:0] npc);
    word_t w;
    bit    expReq;
    @(negedge clk);
    reset      = rst;
    imem_ack   = ack;
    imem_rdata = rdata;
    stall      = stl;
    NPC        = npc;
    #1;
    if (modelKnown) begin
      expReq = (mParked.size() == 0) && !illegalAddr(mPc);
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, expReq});
      if (expReq) checkOutput("imem_addr", imem_addr, mPc);
    end
    if (rst) begin
      mPc    = 32'h3000;
      mD     = '{instr: 32'h0, pc: 32'h3000, exc: 5'd0};
      mValid = 1'b0;
      mParked.delete();
      modelKnown = 1;
    end else if (mParked.size() != 0) begin
      if (!stl) begin
        mD     = mParked.pop_front();
        mValid = 1'b1;
        mPc    = npc;
      end
    end else if (illegalAddr(mPc) || ack) begin
      w = illegalAddr(mPc) ? '{instr: 32'h0, pc: mPc, exc: 5'd4}
                           : '{instr: rdata, pc: mPc, exc: 5'd0};
      if (stl) mParked.push_back(w);
      else begin
        mD     = w;
        mValid = 1'b1;
        mPc    = npc;
      end
    end else if (!stl) begin
      mValid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("F_PC", F_PC, mPc);
    checkOutput("D_valid", {31'b0, D_valid}, {31'b0, mValid});
    checkOutput("D_PC", D_PC, mD.pc);
    checkOutput("D_instr", D_instr, mD.instr);
    checkOutput("D_excCode", {27'b0, D_excCode}, {27'b0, mD.exc});
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] npcR;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; NPC = 32'h0;

    // Reset, with a memory response in the reset cycle that must be ignored.
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678);
    checkOutput("reset_F_PC", F_PC, 32'h3000);
    checkOutput("reset_D_valid", {31'b0, D_valid}, 32'h0);

    // Zero-wait stream: D_PC 0x3000, 0x3004, 0x3008.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hA000_0000 + i, 1'b0, mPc + 32'd4);
      checkOutput("stream_D_PC", D_PC, 32'h3000 + 32'(4 * i));
    end

    // Slow memory: two bubbles, F_PC held.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1111_0000, 1'b0, mPc + 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("slow_F_PC", F_PC, 32'h3004);
    applyStimulus(1'b0, 1'b1, 32'h2222_0004, 1'b0, mPc + 32'd4);
    checkOutput("slow_D_PC", D_PC, 32'h3004);

    // Stall on ack for 0x3008, held two cycles, then released.
    applyStimulus(1'b0, 1'b1, 32'h3333_0008, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h9999_9999, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h3010);
    checkOutput("hold_D_instr", D_instr, 32'h3333_0008);

    // Branch at 0x3000 with delay slot 0x3004, target 0x3100.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1000_0010, 1'b0, 32'h3004);
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h3100);
    checkOutput("branch_F_PC", F_PC, 32'h3100);

    // Reset while holding: parked word must never reach D.
    applyStimulus(1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_hold_D_instr_not_held", {31'b0, D_instr == 32'h5555_AAAA}, 32'h0);

`ifdef F_FETCH_EXC_EN
    // Misaligned and out-of-window fetches.
    applyStimulus(1'b0, 1'b1, 32'h7777_0000, 1'b0, 32'h3002);
    applyStimulus(1'b0, 1'b1, 32'h7777_0001, 1'b0, 32'h7000);
    checkOutput("adel_D_PC", D_PC, 32'h3002);
    checkOutput("adel_D_exc", {27'b0, D_excCode}, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h3000);
    checkOutput("adel_hi_D_PC", D_PC, 32'h7000);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      if (rnd[3:0] == 4'd0)      npcR = $urandom;
      else if (rnd[3:0] < 4'd4)  npcR = 32'h3000 + ($urandom_range(0, 4095) << 2);
      else                       npcR = mPc + 32'd4;
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), $urandom,
                    ($urandom_range(0, 9) < 3), npcR);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
